fifo_rd_stream: RTL and testbench

Read-side adapter that sits directly downstream of the synchronous FIFO (`fifo_design`). It drains the FIFO through its `rd_en`/`empty`/`data_out` port, which has one-cycle registered read latency. It presents the data as a valid/ready stream to the consumer. A 3-entry internal ring sustains one word per cycle with no combinational path from `m_ready` to `fifo_rd_en`.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_rd_stream_if.sv | 22 ++
 rtl/fifo_rd_ring.sv | 51 +++++
 rtl/fifo_rd_stream.sv | 73 +++++++
 tb/tb_fifo_rd_stream.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Definitions shared by the synchronous FIFO and its read-side stream adapter:
// ring geometry, pointer type with its wrap function, and the default word width.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned RING_DEPTH      = 3;

  typedef logic [1:0] ring_ptr_t;
  typedef logic [1:0] ring_occ_t;

  // Advances a ring pointer 0 -> 1 -> 2 -> 0.
  function automatic ring_ptr_t ring_inc(input ring_ptr_t p);
    return (p == ring_ptr_t'(RING_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction

  // Words buffered plus the word (if any) already requested from the FIFO.
  function automatic logic [2:0] ring_load(input ring_occ_t occ, input logic inflight);
    return {1'b0, occ} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying FIFO words to the consumer.
interface fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_ring.sv
// Three-entry ring buffer: storage, read/write pointers and occupancy.
// The caller guarantees push only when space exists and pop only when non-empty.
module fifo_rd_ring
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output ring_occ_t             occ
);

  logic [DATA_WIDTH-1:0] ring_mem [RING_DEPTH];
  ring_ptr_t             rd_ptr;
  ring_ptr_t             wr_ptr;

  // Storage is intentionally left unreset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      ring_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ring_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ring_inc(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = ring_mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a one-cycle-latency synchronous FIFO into a valid/ready stream.
// FIFO requests depend only on registered state, fifo_empty and flush, never on m_ready.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  pop_count,
  fifo_rd_stream_if.master      m
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  ring_occ_t             occ;
  logic                  inflight;
  logic                  capture;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] head;

  // Counting the in-flight word reserves its slot before it lands.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (!rst && !fifo_empty && !flush &&
        (ring_load(occ, inflight) < 3'(RING_DEPTH))) begin
      fifo_rd_en = 1'b1;
    end
  end

  always_comb begin
    capture   = inflight && !flush;
    handshake = m.m_valid && m.m_ready && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count <= '0;
    end else if (handshake) begin
      pop_count <= pop_count + CNT_ONE;
    end
  end

  fifo_rd_ring #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (capture),
    .push_data (fifo_data),
    .pop       (handshake),
    .head      (head),
    .occ       (occ)
  );

  assign m.m_valid = (occ != '0);
  assign m.m_data  = head;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream against a behavioural one-cycle-latency FIFO.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          fifo_rd_en4;
  logic [15:0]   pop_count;
  logic [3:0]    pop_count4;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s  ();
  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s4 ();
  assign s4.m_ready = s.m_ready;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .pop_count  (pop_count),
    .m          (s.master)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en4),
    .flush      (flush),
    .pop_count  (pop_count4),
    .m          (s4.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   rd_pulses = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !s.m_valid) break;
    end
    check(name, exp_q.size(), 0);
  endtask

  // FIFO model: data appears the cycle after an accepted rd_en; empty updates mid-cycle.
  always @(posedge clk) begin
    if (rst) begin
      fifo_data <= '0;
    end else if (fifo_rd_en) begin
      rd_pulses++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fifo_underflow rd_en with empty FIFO at %0t", $time);
      end else begin
        fifo_data <= fq.pop_front();
      end
    end
  end

  always @(negedge clk) fifo_empty = (fq.size() == 0);

  // Monitor: scoreboard pops, stall hold, flush gating, occupancy invariant.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst) begin
      if (int'(dut.occ) + int'(dut.inflight) > 3) begin
        errors++;
        $display("FAIL occ_invariant got %0d expected <=3", int'(dut.occ) + int'(dut.inflight));
      end
      if (prev_stall) begin
        check("hold_valid", s.m_valid, 1);
        check("hold_data", s.m_data, prev_data);
      end
      if (flush) check("flush_no_rd_en", fifo_rd_en, 0);
      check("dut4_rd_en_match", fifo_rd_en4, fifo_rd_en);
      if (s.m_valid && s.m_ready && !flush) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got %0h expected none", s.m_data);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", s.m_data, e);
        end
      end
      prev_stall = s.m_valid && !s.m_ready && !flush;
      prev_data  = s.m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic [15:0] pc_before;
    bit          found;

    s.m_ready = 1'b0;
    fq.push_back(8'hAA);  // FIFO non-empty while in reset
    repeat (2) @(posedge clk); #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", s.m_valid, 0);
    check("rst_pop_count", pop_count, 0);
    check("rst_pop_count4", pop_count4, 0);
    fq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Stream 0x01..0x08 with m_ready high.
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    s.m_ready = 1'b1;
    @(posedge clk); #1;
    check("lat_n1_valid", s.m_valid, 0);
    @(posedge clk); #1;
    check("lat_n2_valid", s.m_valid, 1);
    check("lat_n2_data", s.m_data, 8'h01);
    repeat (8) @(posedge clk); #1;
    check("stream_pop_count", pop_count, 8);
    check("stream_drained", exp_q.size(), 0);
    check("stream_idle_valid", s.m_valid, 0);

    // Backpressure: ring fills, exactly three FIFO pops.
    s.m_ready = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) push_word(8'h10 + DW'(i));
    repeat (10) @(posedge clk); #1;
    check("bp_fifo_pops", rd_pulses, 3);
    check("bp_valid", s.m_valid, 1);
    check("bp_data", s.m_data, 8'h10);
    check("bp_occ_full", dut.occ, 3);
    s.m_ready = 1'b1;
    wait_drain("bp_drain", 40);
    check("bp_pop_count", pop_count, 16);

    // Random ready over 200 words.
    for (int i = 0; i < 200; i++) push_word(DW'(i) ^ 8'h5A);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      s.m_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0) break;
    end
    s.m_ready = 1'b1;
    wait_drain("rand_drain", 10);
    check("rand_pop_count", pop_count, 216);

    // Flush with two words buffered and one in flight; held two cycles.
    s.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h20 + DW'(i));
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (dut.occ == 2'd2 && dut.inflight) begin
        found = 1'b1;
        break;
      end
    end
    check("flush_setup", found, 1);
    pc_before = pop_count;
    flush = 1'b1;
    s.m_ready = 1'b1;
    repeat (3) void'(exp_q.pop_front());
    @(posedge clk); #1;
    check("flush_pop_count", pop_count, pc_before);
    check("flush_valid_cleared", s.m_valid, 0);
    check("flush_gates_rd_en", fifo_rd_en, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("post_flush_rd_en", fifo_rd_en, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("post_flush_first", s.m_data, 8'h23);
    wait_drain("flush_drain", 40);
    check("flush_total_pops", pop_count, pc_before + 16'd5);

    // Reset mid-stream after five handshakes.
    pc_before = pop_count;
    for (int i = 0; i < 12; i++) push_word(8'h30 + DW'(i));
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (pop_count == pc_before + 16'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_rst_reached", found, 1);
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_valid", s.m_valid, 0);
    check("mid_rst_pop_count", pop_count, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'h40 + DW'(i));
    wait_drain("mid_rst_drain", 40);
    check("mid_rst_refill_count", pop_count, 6);

    // Counter wrap on the 4-bit instance.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 17; i++) push_word(8'h50 + DW'(i));
    wait_drain("wrap_drain", 60);
    check("wrap_pop_count16", pop_count, 17);
    check("wrap_pop_count4", pop_count4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
